// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame length and common
// keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_IDLE
    } ps2_state_e;

    // Device clock falls per host-to-device frame: 10 bit slots plus the ACK.
    localparam int PS2_FRAME_FALLS = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizer for an asynchronous PS/2 line with a falling-edge
// pulse; idles high so reset never fakes an edge. Usable by the receiver too.
module ps2_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], i_line};
        end
    end

    assign o_level = r_sync[1];
    assign o_fall  = r_sync[2] & ~r_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device
// clock falls, ACK check. Define PS2_HOST_TX_TIMEOUT_EN to add a stall watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [3:0] ACK_SLOT = 4'(PS2_FRAME_FALLS - 1);

    ps2_state_e       r_state, w_state_next;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_next;
    logic [3:0]       r_bcnt, w_bcnt_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_par, w_par_next;
    logic             r_data_oe, w_data_oe_next;
    logic             r_done, w_done_next;
    logic             r_ack_err, w_ack_err_next;
    logic [1:0]       r_data_sync;
    logic             w_clk_level;
    logic             w_clk_fall;
    logic             w_data_level;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .clrn    (clrn),
        .i_line  (ps2_clk_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_data_sync <= 2'b11;
        end else begin
            r_data_sync <= {r_data_sync[0], ps2_data_in};
        end
    end

    assign w_data_level = r_data_sync[1];

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wdog, w_wdog_next;
    logic            r_timeout, w_timeout_next;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog    <= w_wdog_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_inh_cnt <= '0;
            r_bcnt    <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_inh_cnt <= w_inh_cnt_next;
            r_bcnt    <= w_bcnt_next;
            r_shift   <= w_shift_next;
            r_par     <= w_par_next;
            r_data_oe <= w_data_oe_next;
            r_done    <= w_done_next;
            r_ack_err <= w_ack_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_inh_cnt_next = r_inh_cnt;
        w_bcnt_next    = r_bcnt;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_data_oe_next = r_data_oe;
        w_done_next    = 1'b0;
        w_ack_err_next = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        w_wdog_next    = r_wdog;
        w_timeout_next = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_shift_next   = tx_data;
                    w_par_next     = ps2_odd_parity(tx_data);
                    w_inh_cnt_next = '0;
                    w_state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_next = REQ;
                end else begin
                    w_inh_cnt_next = r_inh_cnt + 1'b1;
                end
            end

            REQ: begin
                // Data stays pulled low into SEND: that is the start bit.
                w_bcnt_next    = '0;
                w_data_oe_next = 1'b1;
                w_state_next   = SEND;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                w_wdog_next    = '0;
`endif
            end

            SEND: begin
                if (w_clk_fall) begin
                    w_bcnt_next = r_bcnt + 4'd1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    w_wdog_next = '0;
`endif
                    if (r_bcnt < 4'd8) begin
                        w_data_oe_next = ~r_shift[0];
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end else if (r_bcnt == 4'd8) begin
                        w_data_oe_next = ~r_par;
                    end else if (r_bcnt != ACK_SLOT) begin
                        w_data_oe_next = 1'b0;
                    end else begin
                        // Device ACK: it pulls data low by this final fall.
                        w_data_oe_next = 1'b0;
                        w_done_next    = ~w_data_level;
                        w_ack_err_next = w_data_level;
                        w_state_next   = WAIT_IDLE;
                    end
                end
`ifdef PS2_HOST_TX_TIMEOUT_EN
                else if (r_wdog == WD_LAST) begin
                    w_data_oe_next = 1'b0;
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_wdog_next = r_wdog + 1'b1;
                end
`endif
            end

            WAIT_IDLE: begin
                if (w_clk_level && w_data_level) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line drives decode straight from state so reset releases them at once.
    assign ps2_clk_oe  = (r_state == INHIBIT) || (r_state == REQ);
    assign ps2_data_oe = (r_state == REQ) || ((r_state == SEND) && r_data_oe);
    assign busy        = (r_state != IDLE);
    assign tx_ready    = ~busy;
    assign done        = r_done;
    assign ack_err     = r_ack_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with a behavioural PS/2 device
// that clocks frames, decodes bits and returns (or withholds) the ACK.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH         = 2000;
    localparam int TO          = 1000;
    localparam int H           = 20;
    localparam int FRAME_LIMIT = 20000;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line;
    logic ps2_data_line;
    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: outcome one-hot {timeout, ack_err, done} and sent bytes.
    logic [2:0] exp_out_q[$];
    logic [7:0] exp_byte_q[$];

    logic dev_nack = 1'b0;
    int   dev_stop_after = 0;
    int   dev_falls = 0;
    logic dev_busy = 1'b0;
    int   t_fall4 = 0;
    logic bits [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device model: waits for request-to-send, then generates 11 clock pulses,
    // sampling data in each high phase before the next fall.
    initial begin
        logic       aborted;
        logic [7:0] rx;
        logic [7:0] eb;
        logic       exp_par;
        forever begin
            @(negedge clk);
            if (clrn && !ps2_clk_oe && ps2_data_oe) begin
                dev_busy = 1'b1;
                dev_falls = 0;
                aborted = 1'b0;
                repeat (H) @(negedge clk);
                for (int k = 1; k <= 11; k++) begin
                    if (dev_stop_after != 0 && k > dev_stop_after) begin
                        aborted = 1'b1;
                        break;
                    end
                    repeat (H / 2) @(negedge clk);
                    bits[k-1] = ps2_data_line;
                    if (k == 11 && !dev_nack) dev_data_low = 1'b1;
                    repeat (H / 2) @(negedge clk);
                    dev_clk_low = 1'b1;
                    dev_falls = k;
                    if (k == 4) t_fall4 = cyc;
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1'b0;
                end
                if (!aborted) begin
                    repeat (4) @(negedge clk);
                    if (!dev_nack) check("busy_while_ack_held", busy, 1);
                    dev_data_low = 1'b0;
                    for (int i = 0; i < 8; i++) rx[i] = bits[i+1];
                    if (exp_byte_q.size() == 0) begin
                        check("unexpected_frame_byte", rx, 0);
                    end else begin
                        eb = exp_byte_q.pop_front();
                        exp_par = (($countones(eb) % 2) == 0);
                        $display("frame: sent %02h decoded %02h par %0d stop %0d", eb, rx, bits[9], bits[10]);
                        check("start_bit", bits[0], 0);
                        check("data_byte", rx, eb);
                        check("parity_bit", bits[9], exp_par);
                        check("stop_bit", bits[10], 1);
                    end
                end
                repeat (4) @(negedge clk);
                dev_busy = 1'b0;
            end
        end
    end

    // Outcome monitor: every done/ack_err/timeout cycle consumes one expectation.
    initial begin
        logic [2:0] got;
        logic [2:0] exp;
        forever begin
            @(negedge clk);
            if (done || ack_err || timeout) begin
                got = {timeout, ack_err, done};
                if (exp_out_q.size() == 0) begin
                    check("unexpected_outcome", got, 0);
                end else begin
                    exp = exp_out_q.pop_front();
                    $display("outcome: got %03b expected %03b", got, exp);
                    check("outcome", got, exp);
                    if (got == 3'b100)
                        check("timeout_delay", (cyc - t_fall4 >= TO) && (cyc - t_fall4 <= TO + 10), 1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic nack, input int stop_after,
                        input logic [2:0] exp_code);
        int n;
        dev_nack = nack;
        dev_stop_after = stop_after;
        dev_falls = 0;
        if (exp_code != 3'b000) exp_out_q.push_back(exp_code);
        if (exp_code == 3'b001 || exp_code == 3'b010) exp_byte_q.push_back(b);
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", tx_ready, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while ((exp_out_q.size() != 0 || dev_busy || !tx_ready) && n < FRAME_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_end_in_time"}, (n < FRAME_LIMIT), 1);
        check({tag, "_ready_after"}, tx_ready, 1);
    endtask

    initial begin
        int n;
        logic [7:0] rb;
        logic rn;

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_pulses", {timeout, ack_err, done}, 0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED: inhibit timing, request ordering, ignored mid-frame request.
        send(PS2_CMD_SET_LED, 1'b0, 0, 3'b001);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("inhibit_cycles", n, INH);
        check("req_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        @(posedge clk);
        #1;
        check("send_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        @(negedge clk);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_end("ed");
        repeat (50) @(negedge clk);
        check("no_second_frame", {busy, ps2_clk_oe}, 2'b00);

        send(PS2_CMD_ENABLE, 1'b0, 0, 3'b001);
        wait_end("f4");
        send(8'h00, 1'b0, 0, 3'b001);
        wait_end("00");
        send(PS2_CMD_RESET, 1'b1, 0, 3'b010);
        wait_end("ff_nack");

        // Reset in the middle of a frame.
        send(PS2_CMD_SET_LED, 1'b0, 5, 3'b000);
        n = 0;
        while (dev_falls < 5 && n < FRAME_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_fall5", (n < FRAME_LIMIT), 1);
        repeat (4) @(negedge clk);
        clrn = 1'b0;
        #1;
        check("abort_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("abort_busy", busy, 0);
        check("abort_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        wait_end("abort");

        send(PS2_CMD_ECHO, 1'b0, 0, 3'b001);
        wait_end("ee");

        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            rn = ($urandom_range(0, 3) == 0);
            send(rb, rn, 0, rn ? 3'b010 : 3'b001);
            wait_end("rand");
        end

`ifdef PS2_HOST_TX_TIMEOUT_EN
        send(PS2_CMD_ENABLE, 1'b0, 4, 3'b100);
        wait_end("timeout");
        check("timeout_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
`endif

        repeat (20) @(negedge clk);
        check("outcome_queue_drained", exp_out_q.size(), 0);
        check("byte_queue_drained", exp_byte_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(90000 * 10);
        n_fail++;
        $display("FAIL global_time_limit: simulation still running at cycle %0d, expected finish earlier", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LED, 0xFF reset) to the keyboard over the shared open-drain ps2_clk/ps2_data lines.
- Sits beside the existing ps2_keyboard receiver. Converts a byte handshake into the PS/2 request-to-send sequence, then clocks bits out on device-generated clock edges and checks the device ACK.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles ps2_clk is held low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, max clk cycles between device clock falling edges (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  block idle; tx_data is accepted when tx_valid && tx_ready.
- ps2_clk_in  in  1  sensed PS/2 clock line.
- ps2_data_in  in  1  sensed PS/2 data line.
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse: frame sent and ACK seen (data low).
- ack_err  out  1  one-cycle pulse: frame sent but data high at the ACK edge.
- timeout  out  1  one-cycle pulse: device clock stalled (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async, clrn=0):
  - state=IDLE; ps2_clk_oe=0, ps2_data_oe=0 (both lines released immediately, including mid-frame).
  - tx_ready=1, busy=0, done=0, ack_err=0, timeout=0; counters cleared.
- Input conditioning: ps2_clk_in passes through a 3-flop synchronizer; fall = previous synced value 1 and current 0. ps2_data_in gets a 2-flop synchronizer. Edge detection adds 3 cycles of latency.
- Parity: par = ~^byte (odd parity). A frame is start(0), d0..d7 LSB first, par, stop(1).
- States:
  - IDLE: tx_ready=1. On tx_valid, latch the byte into a shift register, compute par, and go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1, data_oe=1 for 1 cycle, then go to SEND.
  - SEND: clk_oe=0. data_oe holds the start bit (1). The bit counter bcnt starts at 0 and increments on every fall.
    - falls 1..8: data_oe = ~d[bcnt-1].
    - fall 9: data_oe = ~par.
    - fall 10: data_oe = 0 (stop bit, line released).
    - fall 11: sample synced data. Pulse done if 0, ack_err if 1. Go to WAIT_IDLE.
  - WAIT_IDLE: both oe=0. Stay until synced clk=1 and data=1, then go to IDLE. tx_ready rises that cycle.
- busy = (state != IDLE); tx_ready = ~busy.
- tx_valid while busy is ignored; the byte is not queued, and tx_data changes after acceptance have no effect.
- Falls seen in INHIBIT/REQ are ignored. Only falls in SEND advance bcnt.
- done and ack_err are mutually exclusive; each is high for exactly 1 cycle per frame.
- A back-to-back tx_valid held high starts the next frame the cycle after tx_ready rises.

Optional Feature:
- Macro: PS2_HOST_TX_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entering SEND and on each fall.
  - If it reaches TIMEOUT_CYCLES in SEND, both oe go to 0, timeout pulses for 1 cycle, and the state returns to IDLE directly (no done/ack_err).
- Undefined: no watchdog logic; timeout is tied 0; SEND waits indefinitely.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE}.
  - PS2_FRAME_FALLS=11.
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
- Sub-module ps2_sync_edge: 3-flop synchronizer plus falling-edge pulse. It is natural to share it with the receiver.

Test Plan:
- Send 0xED, device model clocks 11 falls, ACK low -> bits sampled on rising edges are 0,1,0,1,1,0,1,1,1,1 (start, LSB-first 0xED, par=1); stop releases data; done pulses once; tx_ready returns after lines idle.
- Send 0xF4 -> par bit = 0; send 0x00 -> par bit = 1; model decodes 0xF4 and 0x00 with no parity error.
- Send 0xFF, model leaves data high at fall 11 -> ack_err pulses, done stays 0, return to IDLE.
- ps2_clk_oe stays high for exactly 10000 cycles after acceptance, then data_oe rises one cycle before clk_oe drops; tx_valid pulsed mid-frame with 0x55 -> ignored, no second frame.
- Assert clrn low at fall 5 -> both oe drop immediately, busy=0, tx_ready=1; the next 0xEE frame completes with done.
- (PS2_HOST_TX_TIMEOUT_EN, TIMEOUT_CYCLES=1000) model stops after 4 falls -> timeout pulses 1000 cycles after the 4th fall, lines released, IDLE.
